// File: rtl/bus_load_regs_pkg.sv
// Shared definitions for the register-load datapath and the bus source mux.
//   - 3-bit source/destination selector codes (same encoding on both sides)
//   - bit positions inside the 4-bit inr/clr strobe vectors
//   - write FSM state encoding
package bus_load_regs_pkg;

    typedef logic [2:0] sel_t;

    localparam sel_t SEL_NONE = 3'd0;
    localparam sel_t SEL_AR   = 3'd1;
    localparam sel_t SEL_PC   = 3'd2;
    localparam sel_t SEL_DR   = 3'd3;
    localparam sel_t SEL_AC   = 3'd4;
    localparam sel_t SEL_IR   = 3'd5;
    localparam sel_t SEL_TR   = 3'd6;
    localparam sel_t SEL_MEM  = 3'd7;

    localparam int STB_AR = 0;
    localparam int STB_PC = 1;
    localparam int STB_DR = 2;
    localparam int STB_AC = 3;

    localparam logic [1:0] WR_IDLE = 2'd0;
    localparam logic [1:0] WR_REQ  = 2'd1;
    localparam logic [1:0] WR_DONE = 2'd2;

endpackage

// File: rtl/bus_load_regs_cpu_reg.sv
// cpu_reg: one architectural register with clear, load and increment.
// Priority: clr_i > ld_i > inr_i > hold. Increment wraps modulo 2**W.
// Ports:
//   clk, rst_n  clock / async active-low reset (clears to 0)
//   ld_i        load d_i
//   inr_i       increment
//   clr_i       clear
//   d_i [W]     load value
//   q_o [W]     register contents
module cpu_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_i,
    input  logic         inr_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (ld_i) begin
            q_d = d_i;
        end else if (inr_i) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/bus_load_regs.sv
// bus_load_regs: the register file side of the common bus plus a
// request/acknowledge memory write port.
// Ports:
//   clk, rst_n          clock / async active-low reset
//   bus [DATA_W]        common bus value
//   ld_sel [3]          load destination (shares codes with bus source mux)
//   inr, clr [4]        increment / clear strobes {AC,DR,PC,AR}
//   ar, pc [ADDR_W]     address registers
//   dr, ac, ir, tr      data registers
//   mem_wr_req/ack      write handshake
//   mem_addr, mem_wdata latched write address/data
//   wr_busy, wr_done    FSM not idle / write accepted pulse
//   wr_drop             pulse: write request arrived while busy
//
// Write FSM
//   state   | meaning
//   IDLE    | no write pending; ld_sel==MEM latches addr/data
//   REQ     | mem_wr_req high, waiting for mem_wr_ack
//   DONE    | write accepted, wr_done high for this cycle only
module bus_load_regs
    import bus_load_regs_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus,
    input  logic [2:0]        ld_sel,
    input  logic [3:0]        inr,
    input  logic [3:0]        clr,
    output logic [ADDR_W-1:0] ar,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] dr,
    output logic [DATA_W-1:0] ac,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] tr,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wr_ack,
    output logic              wr_busy,
    output logic              wr_done,
    output logic              wr_drop
);

    cpu_reg #(.W(ADDR_W)) u_ar (
        .clk(clk), .rst_n(rst_n),
        .ld_i(ld_sel == SEL_AR), .inr_i(inr[STB_AR]), .clr_i(clr[STB_AR]),
        .d_i(bus[ADDR_W-1:0]), .q_o(ar)
    );

    cpu_reg #(.W(ADDR_W)) u_pc (
        .clk(clk), .rst_n(rst_n),
        .ld_i(ld_sel == SEL_PC), .inr_i(inr[STB_PC]), .clr_i(clr[STB_PC]),
        .d_i(bus[ADDR_W-1:0]), .q_o(pc)
    );

    cpu_reg #(.W(DATA_W)) u_dr (
        .clk(clk), .rst_n(rst_n),
        .ld_i(ld_sel == SEL_DR), .inr_i(inr[STB_DR]), .clr_i(clr[STB_DR]),
        .d_i(bus), .q_o(dr)
    );

    cpu_reg #(.W(DATA_W)) u_ac (
        .clk(clk), .rst_n(rst_n),
        .ld_i(ld_sel == SEL_AC), .inr_i(inr[STB_AC]), .clr_i(clr[STB_AC]),
        .d_i(bus), .q_o(ac)
    );

    // IR and TR are load-only.
    cpu_reg #(.W(DATA_W)) u_ir (
        .clk(clk), .rst_n(rst_n),
        .ld_i(ld_sel == SEL_IR), .inr_i(1'b0), .clr_i(1'b0),
        .d_i(bus), .q_o(ir)
    );

    cpu_reg #(.W(DATA_W)) u_tr (
        .clk(clk), .rst_n(rst_n),
        .ld_i(ld_sel == SEL_TR), .inr_i(1'b0), .clr_i(1'b0),
        .d_i(bus), .q_o(tr)
    );

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              drop_q, drop_d;
    logic              wr_sel;

    assign wr_sel = (ld_sel == SEL_MEM);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            WR_IDLE: begin
                if (wr_sel) begin
                    // ar is the registered value, so a same-cycle AR
                    // update does not leak into the write address.
                    addr_d  = ar;
                    wdata_d = bus;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (mem_wr_ack) begin
                    state_d = WR_DONE;
                end
            end
            WR_DONE: begin
                state_d = WR_IDLE;
            end
            default: begin
                state_d = WR_IDLE;
            end
        endcase
        drop_d = wr_sel && (state_q != WR_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WR_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            drop_q  <= drop_d;
        end
    end

    assign mem_wr_req = (state_q == WR_REQ);
    assign wr_done    = (state_q == WR_DONE);
    assign wr_busy    = (state_q != WR_IDLE);
    assign wr_drop    = drop_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: doc/bus_load_regs.md
BUS_LOAD_REGS -- requirements
Module: bus_load_regs

Interface
REQ-001 Parameter DATA_W, default 16, common bus and 16-bit register width.
REQ-002 Parameter ADDR_W, default 12, AR/PC and memory address width.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 bus  input  DATA_W  common bus value (driven by source mux).
REQ-006 ld_sel  input  3  load destination: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 memory write; encoding identical to bus source selector.
REQ-007 inr  input  4  increment strobes {AC,DR,PC,AR} (bit0 = AR).
REQ-008 clr  input  4  clear strobes {AC,DR,PC,AR} (bit0 = AR).
REQ-009 ar, pc  output  ADDR_W each  register contents.
REQ-010 dr, ac, ir, tr  output  DATA_W each  register contents.
REQ-011 mem_wr_req  output  1  write request, held until acknowledged.
REQ-012 mem_addr  output  ADDR_W  latched write address.
REQ-013 mem_wdata  output  DATA_W  latched write data.
REQ-014 mem_wr_ack  input  1  memory accepts write when high with mem_wr_req.
REQ-015 wr_busy  output  1  high while write FSM not IDLE.
REQ-016 wr_done  output  1  one-cycle pulse after accepted write.
REQ-017 wr_drop  output  1  one-cycle pulse when a write request is rejected.

Function
REQ-018 Per register, priority SHALL be clr > load (ld_sel match) > inr > hold, evaluated each cycle.
REQ-019 Load of AR/PC SHALL take bus[ADDR_W-1:0]; upper bus bits ignored.
REQ-020 Load of DR/AC/IR/TR SHALL take full bus; IR and TR have no inr/clr.
REQ-021 Increment SHALL be modulo width: PC 0xFFF+1 -> 0x000, AC 0xFFFF+1 -> 0x0000, no carry output.
REQ-022 Register updates SHALL be visible on outputs one cycle after the controlling edge (latency 1).
REQ-023 Write FSM states SHALL be IDLE, REQ, DONE.
REQ-024 IDLE: ld_sel==7 SHALL latch mem_wdata=bus and mem_addr=ar (value before any same-cycle AR update), go REQ.
REQ-025 REQ: mem_wr_req=1, address/data stable; sampled mem_wr_ack=1 -> DONE; else stay REQ indefinitely.
REQ-026 DONE: mem_wr_req=0, wr_done=1 for exactly that cycle, next state IDLE unconditionally.
REQ-027 ld_sel==7 in REQ or DONE SHALL be ignored (no relatch) and SHALL pulse wr_drop next cycle.
REQ-028 Register loads/increments/clears SHALL proceed independently of FSM state, including AR changes during REQ (mem_addr unaffected).
REQ-029 mem_wr_ack while in IDLE or DONE SHALL be ignored.
REQ-030 wr_busy SHALL equal (state != IDLE).

Reset
REQ-031 rst_n low SHALL immediately clear ar, pc, dr, ac, ir, tr, mem_addr, mem_wdata to 0.
REQ-032 rst_n low SHALL force FSM to IDLE, mem_wr_req, wr_busy, wr_done, wr_drop to 0, aborting any pending write without wr_done.
REQ-033 First active edge after rst_n rises SHALL be treated as normal operation.

Structure
REQ-034 Shared package SHALL hold the 3-bit source/destination codes (NONE, AR, PC, DR, AC, IR, TR, MEM), strobe bit indices, and FSM state encoding, shared with the bus source mux.
REQ-035 One sub-module, cpu_reg (parameterised width, ld/inr/clr, async active-low reset), SHALL be instantiated per register; FSM stays in the top level.

Verification
REQ-036 bus=0x1ABC, ld_sel=1 one cycle -> ar=0xABC next cycle; ld_sel=2 -> pc=0xABC.
REQ-037 pc=0xFFF, inr[1]=1 -> pc=0x000; ac=0x0041, clr[3]=1 with ld_sel=4, bus=0x5555 -> ac=0x0000.
REQ-038 ar=0x123, bus=0xBEEF, ld_sel=7; ack held low 3 cycles then high -> req high 4 cycles, addr=0x123, wdata=0xBEEF stable, wr_done one cycle later.
REQ-039 ld_sel=7 while in REQ with bus=0x0000 -> wr_drop pulse, mem_wdata stays 0xBEEF; ld_sel=1 during REQ changes ar, mem_addr unchanged.
REQ-040 rst_n low mid-REQ -> all outputs 0 asynchronously, no wr_done; after release ack=1 causes no activity.
